// File: rtl/dds_pkg.sv
// ----------------------------------------------------------------------------
// dds_pkg
// Shared types and constants for the DDS wave generator.
//  - sweep_state_e : triangle-sweep FSM states
//  - LFSR_SEED/TAPS: phase-dither LFSR (x^16+x^14+x^13+x^11+1, right-shifting
//                    Fibonacci form, bit 0 is the oldest bit)
//  - mid_code()    : unsigned mid-scale code for a given sample width
//  - lfsr_next()   : one LFSR step
// ----------------------------------------------------------------------------
package dds_pkg;

   typedef enum logic [1:0] {
      SW_IDLE = 2'd0,
      SW_UP   = 2'd1,
      SW_DOWN = 2'd2
   } sweep_state_e;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Feedback taps at bits 0,2,3,5 realise x^16+x^14+x^13+x^11+1.
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   function automatic int unsigned mid_code(input int unsigned w);
      return 32'd1 << (w - 1);
   endfunction

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {^(s & LFSR_TAPS), s[15:1]};
   endfunction

endpackage

// File: rtl/dds_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// dds_sweep_ctrl
// Tuning-word owner: arbitrates direct load, sweep control and step pulses,
// runs the triangle-sweep FSM and its tick divider, saturates step/sweep
// results to [FTW_MIN, FTW_MAX].
// Ports:
//  clk, rst_n                 clock, async active-low reset
//  i_step_up/i_step_down      one-cycle step pulses (ignored while sweeping)
//  i_ftw_load, i_ftw_in       direct load (highest priority, unclamped)
//  i_sweep_start/abort        sweep control pulses
//  i_sweep_lo/hi/inc/div      live sweep bounds, increment, tick divider
//  o_ftw                      current tuning word
//  o_sweep_busy               FSM not IDLE
// ----------------------------------------------------------------------------
module dds_sweep_ctrl
   import dds_pkg::*;
#(
   parameter int          FTW_W   = 20,
   parameter int unsigned FTW_RST = 11280,
   parameter int unsigned FTW_MIN = 1,
   parameter int unsigned FTW_MAX = (1 << FTW_W) - 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_step_up,
   input  logic             i_step_down,
   input  logic             i_ftw_load,
   input  logic [FTW_W-1:0] i_ftw_in,
   input  logic             i_sweep_start,
   input  logic             i_sweep_abort,
   input  logic [FTW_W-1:0] i_sweep_lo,
   input  logic [FTW_W-1:0] i_sweep_hi,
   input  logic [FTW_W-1:0] i_sweep_inc,
   input  logic [15:0]      i_sweep_div,
   output logic [FTW_W-1:0] o_ftw,
   output logic             o_sweep_busy
);

   localparam int EW = FTW_W + 1;
   localparam logic [EW-1:0] C_MIN_X = EW'(FTW_MIN);
   localparam logic [EW-1:0] C_MAX_X = EW'(FTW_MAX);

   sweep_state_e     r_state, w_state_nxt;
   logic [FTW_W-1:0] r_ftw, w_ftw_nxt;
   logic [15:0]      r_cnt, w_cnt_nxt;

   logic [EW-1:0]    w_sum, w_diff;
   logic             w_up_hit, w_dn_hit, w_tick, w_start_ok;

   // Clamp a one-bit-wider intermediate into the legal tuning-word range.
   function automatic logic [FTW_W-1:0] sat(input logic [EW-1:0] v);
      if (v < C_MIN_X)      return C_MIN_X[FTW_W-1:0];
      else if (v > C_MAX_X) return C_MAX_X[FTW_W-1:0];
      else                  return v[FTW_W-1:0];
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= SW_IDLE;
         r_ftw   <= FTW_W'(FTW_RST);
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ftw   <= w_ftw_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Extra MSB keeps add/subtract free of overflow; in w_diff it is the borrow.
   assign w_sum      = {1'b0, r_ftw} + {1'b0, i_sweep_inc};
   assign w_diff     = {1'b0, r_ftw} - {1'b0, i_sweep_inc};
   assign w_up_hit   = (w_sum >= {1'b0, i_sweep_hi});
   assign w_dn_hit   = w_diff[FTW_W] || (w_diff <= {1'b0, i_sweep_lo});
   // ">=" so a live shrink of the divider cannot strand the counter above it.
   assign w_tick     = (r_state != SW_IDLE) && (r_cnt >= i_sweep_div);
   assign w_start_ok = i_sweep_start && (i_sweep_lo < i_sweep_hi);

   always_comb begin
      w_state_nxt = r_state;
      w_ftw_nxt   = r_ftw;
      w_cnt_nxt   = r_cnt;
      if (i_ftw_load) begin
         w_state_nxt = SW_IDLE;
         w_ftw_nxt   = i_ftw_in;
         w_cnt_nxt   = '0;
      end else if (i_sweep_abort) begin
         w_state_nxt = SW_IDLE;
         w_cnt_nxt   = '0;
      end else if (w_start_ok) begin
         w_state_nxt = SW_UP;
         w_ftw_nxt   = i_sweep_lo;
         w_cnt_nxt   = '0;
      end else if (r_state != SW_IDLE) begin
         w_cnt_nxt = w_tick ? 16'd0 : r_cnt + 16'd1;
         // Zero increment freezes both the word and the direction.
         if (w_tick && (i_sweep_inc != '0)) begin
            case (r_state)
               SW_UP: begin
                  if (w_up_hit) begin
                     w_ftw_nxt   = sat({1'b0, i_sweep_hi});
                     w_state_nxt = SW_DOWN;
                  end else begin
                     w_ftw_nxt = sat(w_sum);
                  end
               end
               SW_DOWN: begin
                  if (w_dn_hit) begin
                     w_ftw_nxt   = sat({1'b0, i_sweep_lo});
                     w_state_nxt = SW_UP;
                  end else begin
                     w_ftw_nxt = sat(w_diff);
                  end
               end
               default: w_state_nxt = SW_IDLE;
            endcase
         end
      end else if (i_step_down) begin
         // Down wins over a simultaneous up.
         w_ftw_nxt = ({1'b0, r_ftw} <= C_MIN_X) ? C_MIN_X[FTW_W-1:0]
                                                : sat({1'b0, r_ftw} - EW'(1));
      end else if (i_step_up) begin
         w_ftw_nxt = sat({1'b0, r_ftw} + EW'(1));
      end
   end

   assign o_ftw        = r_ftw;
   assign o_sweep_busy = (r_state != SW_IDLE);

endmodule

// File: rtl/dds_wave_gen.sv
// ----------------------------------------------------------------------------
// dds_wave_gen
// DDS for the DA output path: phase accumulator, sine-ROM addressing,
// bit-keyed amplitude (full sine / mini sine / constant mid) and DAC output
// register. Tuning-word control lives in dds_sweep_ctrl.
// Optional build macro: DDS_PHASE_DITHER_EN adds LFSR dither to the ROM
// address only (phase output stays undithered).
// Ports:
//  clk, rst_n                  clock, async active-low reset
//  i_step_up/down, i_ftw_load, i_ftw_in, i_sweep_*   tuning-word control
//  i_bit_in, i_mini_en         amplitude keying
//  o_rom_addr / i_rom_data     sine ROM (1-cycle synchronous read)
//  o_da_clk, o_da_data         DAC clock (~clk) and registered sample
//  o_ftw, o_phase, o_sweep_busy  status for display / phase detector
// Latency: accumulator update -> o_da_data is 3 registers (addr, ROM, output).
// ----------------------------------------------------------------------------
module dds_wave_gen
   import dds_pkg::*;
#(
   parameter int          ACC_W      = 24,
   parameter int          ADDR_W     = 10,
   parameter int          DATA_W     = 10,
   parameter int          FTW_W      = 20,
   parameter int unsigned FTW_RST    = 11280,
   parameter int unsigned FTW_MIN    = 1,
   parameter int unsigned FTW_MAX    = (1 << FTW_W) - 1,
   parameter int          MINI_SHIFT = 3,
   parameter int          MINI_MAX   = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_step_up,
   input  logic              i_step_down,
   input  logic              i_ftw_load,
   input  logic [FTW_W-1:0]  i_ftw_in,
   input  logic              i_sweep_start,
   input  logic              i_sweep_abort,
   input  logic [FTW_W-1:0]  i_sweep_lo,
   input  logic [FTW_W-1:0]  i_sweep_hi,
   input  logic [FTW_W-1:0]  i_sweep_inc,
   input  logic [15:0]       i_sweep_div,
   input  logic              i_bit_in,
   input  logic              i_mini_en,
   output logic [ADDR_W-1:0] o_rom_addr,
   input  logic [DATA_W-1:0] i_rom_data,
   output logic              o_da_clk,
   output logic [DATA_W-1:0] o_da_data,
   output logic [FTW_W-1:0]  o_ftw,
   output logic [ACC_W-1:0]  o_phase,
   output logic              o_sweep_busy
);

   localparam logic [DATA_W-1:0] MID     = DATA_W'(mid_code(DATA_W));
   localparam logic [DATA_W-1:0] C_MINIM = DATA_W'(MINI_MAX);

   logic [FTW_W-1:0]  w_ftw;
   logic [ACC_W-1:0]  r_acc, w_acc_nxt;
   logic [ADDR_W-1:0] r_rom_addr, w_addr;
   logic [1:0]        r_bit_pipe, r_mini_pipe;
   logic [DATA_W-1:0] r_da_data, w_sample;
   logic [DATA_W-1:0] w_mag, w_shr, w_amp, w_mini;
   logic              w_ge;

   dds_sweep_ctrl #(
      .FTW_W   (FTW_W),
      .FTW_RST (FTW_RST),
      .FTW_MIN (FTW_MIN),
      .FTW_MAX (FTW_MAX)
   ) u_sweep (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_step_up     (i_step_up),
      .i_step_down   (i_step_down),
      .i_ftw_load    (i_ftw_load),
      .i_ftw_in      (i_ftw_in),
      .i_sweep_start (i_sweep_start),
      .i_sweep_abort (i_sweep_abort),
      .i_sweep_lo    (i_sweep_lo),
      .i_sweep_hi    (i_sweep_hi),
      .i_sweep_inc   (i_sweep_inc),
      .i_sweep_div   (i_sweep_div),
      .o_ftw         (w_ftw),
      .o_sweep_busy  (o_sweep_busy)
   );

   // Accumulator wraps naturally modulo 2^ACC_W.
   assign w_acc_nxt = r_acc + ACC_W'(w_ftw);

`ifdef DDS_PHASE_DITHER_EN
   localparam int DITH_W = ((ACC_W - ADDR_W) > 16) ? 16 : (ACC_W - ADDR_W);

   logic [15:0]      r_lfsr;
   logic [ACC_W-1:0] w_dith_acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_lfsr <= LFSR_SEED;
      else        r_lfsr <= lfsr_next(r_lfsr);
   end

   // Dither only perturbs the truncated address; r_acc itself is untouched.
   assign w_dith_acc = w_acc_nxt + ACC_W'(r_lfsr[DITH_W-1:0]);
   assign w_addr     = w_dith_acc[ACC_W-1 -: ADDR_W];
`else
   assign w_addr = w_acc_nxt[ACC_W-1 -: ADDR_W];
`endif

   // Mini sine: shrink the deviation from mid, clip, keep its sign.
   always_comb begin
      w_ge  = (i_rom_data >= MID);
      w_mag = w_ge ? (i_rom_data - MID) : (MID - i_rom_data);
      w_shr = w_mag >> MINI_SHIFT;
      w_amp = (w_shr > C_MINIM) ? C_MINIM : w_shr;
      w_mini = w_ge ? (MID + w_amp) : (MID - w_amp);
      w_sample = MID;
      if (r_bit_pipe[1])       w_sample = i_rom_data;
      else if (r_mini_pipe[1]) w_sample = w_mini;
   end

   // Keying bits travel two stages so they meet the ROM word whose address
   // was registered on the same edge that sampled them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc       <= '0;
         r_rom_addr  <= '0;
         r_bit_pipe  <= '0;
         r_mini_pipe <= '0;
         r_da_data   <= MID;
      end else begin
         r_acc       <= w_acc_nxt;
         r_rom_addr  <= w_addr;
         r_bit_pipe  <= {r_bit_pipe[0], i_bit_in};
         r_mini_pipe <= {r_mini_pipe[0], i_mini_en};
         r_da_data   <= w_sample;
      end
   end

   assign o_rom_addr = r_rom_addr;
   assign o_da_clk   = ~clk;
   assign o_da_data  = r_da_data;
   assign o_ftw      = w_ftw;
   assign o_phase    = r_acc;

endmodule
